id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DW, default 32: datapath width.
REQ-002 Parameter RW, default 5: register-index width.
REQ-003 clk  in  1  rising-edge clock; single clock domain.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 stall  in  1  hold current EX contents.
REQ-006 flush  in  1  convert EX slot into a bubble.
REQ-007 id_valid  in  1  decode slot holds a real instruction.
REQ-008 id_rs_data, id_rt_data  in  DW  register-file read data.
REQ-009 id_imm  in  DW  sign-extended immediate.
REQ-010 id_rs, id_rt, id_rd  in  RW  source/destination indices.
REQ-011 id_alu_contr  in  4  ALU operation code (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100).
REQ-012 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decode control.
REQ-013 mem_reg_write, wb_reg_write  in  1  later-stage write enables.
REQ-014 mem_rd, wb_rd  in  RW  later-stage destinations.
REQ-015 mem_result, wb_result  in  DW  later-stage results.
REQ-016 ex_valid  out  1  EX slot valid.
REQ-017 alu_a, alu_b  out  DW  ALU operands.
REQ-018 alu_contr  out  4  ALU operation code.
REQ-019 ex_store_data  out  DW  forwarded rt value for stores.
REQ-020 ex_wr_reg  out  RW  rd if reg_dst else rt.
REQ-021 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  gated control (0 when ex_valid=0).

Function
REQ-022 Latency: decode inputs appear on outputs one clk edge after capture.
REQ-023 Capture: each edge with stall=0 and flush=0 SHALL load all id_* fields; ex_valid<=id_valid.
REQ-024 stall=1, flush=0 SHALL hold every register unchanged.
REQ-025 flush=1 SHALL clear ex_valid and all registered control bits regardless of stall (flush wins).
REQ-026 Forwarding SHALL be combinational on registered rs/rt: MEM hit if mem_reg_write, mem_rd!=0, mem_rd==index; else WB hit under same rules; else registered data.
REQ-027 MEM hit SHALL take priority over simultaneous WB hit to same index.
REQ-028 Index 0 SHALL never forward; registered data passes unchanged.
REQ-029 alu_a = forwarded rs; ex_store_data = forwarded rt; alu_b = registered imm if alu_src else forwarded rt.
REQ-030 Invalid slot: ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg SHALL be 0; alu_contr SHALL be 0010.
REQ-031 Operands pass through without width change or arithmetic.

Reset
REQ-032 rst=1 SHALL asynchronously clear all registers: ex_valid=0, data/indices 0, alu_contr=0010, all control 0.
REQ-033 Reset mid-stall or mid-flush SHALL override both; first capture follows first edge after rst deasserts.

Structure
REQ-034 ALU opcode constants and DW/RW defaults SHALL reside in shared package mips_pkg.
REQ-035 One sub-module fwd_mux (index, reg data, MEM/WB signals -> operand) SHALL be instantiated twice (rs, rt).

Verification
REQ-036 Capture: id_rs_data=5, id_rt_data=3, contr=0110, alu_src=0 -> next cycle alu_a=5, alu_b=3, alu_contr=0110, ex_valid=1.
REQ-037 Priority: rs=8, mem_rd=8 result 0xAA, wb_rd=8 result 0xBB, both writes 1 -> alu_a=0xAA; drop mem_reg_write -> 0xBB.
REQ-038 Zero register: rs=0, mem_rd=0, mem_reg_write=1 result 0xFF, id_rs_data=0 -> alu_a=0.
REQ-039 Stall+flush: stall=1 two cycles -> outputs constant; stall=1, flush=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
REQ-040 Immediate: alu_src=1, imm=0xFFFFFFFC, rt forwarded 7 -> alu_b=0xFFFFFFFC, ex_store_data=7.
REQ-041 Async reset: rst asserted between edges with valid SW in EX -> ex_mem_write=0, ex_valid=0 immediately, before next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: width defaults, ALU opcodes and the
// control bundle carried from decode into execute.
package mips_pkg;

   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef struct packed {
      logic       alu_src;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic [3:0] alu_contr;
   } ex_ctrl_t;

   // Control word of a bubble: no side effects, harmless ADD
   localparam ex_ctrl_t CTRL_NOP = '{
      alu_src:    1'b0,
      reg_dst:    1'b0,
      reg_write:  1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      alu_contr:  ALU_ADD
   };

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks the newest in-flight value for one register index,
// MEM stage first, then WB, else the register-file copy.
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] reg_data,
   input  logic          mem_reg_write,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_result,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] operand
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == idx);
   assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == idx);

   always_comb begin
      operand = reg_data;
      if (wb_hit)  operand = wb_result;
      if (mem_hit) operand = mem_result;
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall/flush control and EX-side operand
// forwarding from the MEM and WB stages.
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [3:0]    id_alu_contr,
   input  logic          id_alu_src,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic          mem_reg_write,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] mem_rd,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] mem_result,
   input  logic [DW-1:0] wb_result,
   output logic          ex_valid,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [3:0]    alu_contr,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_wr_reg,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg
);

   logic          valid_q;
   ex_ctrl_t      ctrl_q;
   logic [DW-1:0] rs_data_q;
   logic [DW-1:0] rt_data_q;
   logic [DW-1:0] imm_q;
   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
   logic [RW-1:0] rd_q;
   logic [DW-1:0] rs_fwd;
   logic [DW-1:0] rt_fwd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
      end else if (flush) begin
         // Bubble: operands are left in place, only control is killed
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
      end else if (!stall) begin
         valid_q   <= id_valid;
         ctrl_q    <= '{
            alu_src:    id_alu_src,
            reg_dst:    id_reg_dst,
            reg_write:  id_reg_write,
            mem_read:   id_mem_read,
            mem_write:  id_mem_write,
            mem_to_reg: id_mem_to_reg,
            alu_contr:  id_alu_contr
         };
         rs_data_q <= id_rs_data;
         rt_data_q <= id_rt_data;
         imm_q     <= id_imm;
         rs_q      <= id_rs;
         rt_q      <= id_rt;
         rd_q      <= id_rd;
      end
   end

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .idx           (rs_q),
      .reg_data      (rs_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .operand       (rs_fwd)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .idx           (rt_q),
      .reg_data      (rt_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .operand       (rt_fwd)
   );

   assign ex_valid      = valid_q;
   assign alu_a         = rs_fwd;
   assign ex_store_data = rt_fwd;
   assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
   assign ex_wr_reg     = ctrl_q.reg_dst ? rd_q : rt_q;
   assign alu_contr     = valid_q ? ctrl_q.alu_contr : ALU_ADD;
   assign ex_reg_write  = valid_q & ctrl_q.reg_write;
   assign ex_mem_read   = valid_q & ctrl_q.mem_read;
   assign ex_mem_write  = valid_q & ctrl_q.mem_write;
   assign ex_mem_to_reg = valid_q & ctrl_q.mem_to_reg;

endmodule
